// File: rtl/my_processor_pio_out_if.sv
// Avalon-MM slave bus bundle for the PIO output block: word address, select,
// active-low write strobe, write data and zero-wait-state read data.
interface my_processor_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/my_processor_pio_out.sv
// PIO output port with DATA/SET/CLEAR/TOGGLE registers and an optional blink
// engine, compiled in when MY_PROCESSOR_PIO_OUT_BLINK_EN is defined.
module my_processor_pio_out #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  my_processor_pio_out_if.slave  bus,
  output logic [WIDTH-1:0]       out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [31:0]      rd_data;
  logic             unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_bits   = bus.writedata[WIDTH-1:0];
  // Upper write-data bits are intentionally discarded for narrow ports.
  assign unused_wd = &{1'b0, bus.writedata};

  always_comb begin
    data_next = data_reg;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:   data_next = wr_bits;
        ADDR_SET:    data_next = data_reg | wr_bits;
        ADDR_CLEAR:  data_next = data_reg & ~wr_bits;
        ADDR_TOGGLE: data_next = data_reg ^ wr_bits;
        default:     data_next = data_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
    end
  end

`ifdef MY_PROCESSOR_PIO_OUT_BLINK_EN
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [WIDTH-1:0]    mask_reg;
  logic [WIDTH-1:0]    mask_next;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] period_next;
  logic [PERIOD_W-1:0] cnt_reg;
  logic [PERIOD_W-1:0] cnt_next;
  logic                phase_reg;
  logic                phase_next;

  always_comb begin
    mask_next   = mask_reg;
    period_next = period_reg;
    cnt_next    = cnt_reg;
    phase_next  = phase_reg;

    // A zero period parks the blinker with phase low.
    if (period_reg == '0) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (cnt_reg == period_reg - ONE) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end else begin
      cnt_next   = cnt_reg + ONE;
    end

    if (wr_en && bus.address == ADDR_MASK) begin
      mask_next = wr_bits;
    end
    // Reloading the period restarts the blink from the low half.
    if (wr_en && bus.address == ADDR_PERIOD) begin
      period_next = bus.writedata[PERIOD_W-1:0];
      cnt_next    = '0;
      phase_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg   <= '0;
      period_reg <= '0;
      cnt_reg    <= '0;
      phase_reg  <= 1'b0;
    end else begin
      mask_reg   <= mask_next;
      period_reg <= period_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_blink
    assign out_port[gi] = data_reg[gi] ^ (mask_reg[gi] & phase_reg);
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      ADDR_DATA:   rd_data[WIDTH-1:0]    = data_reg;
      ADDR_MASK:   rd_data[WIDTH-1:0]    = mask_reg;
      ADDR_PERIOD: rd_data[PERIOD_W-1:0] = period_reg;
      ADDR_STATUS: rd_data[0]            = phase_reg;
      default:     rd_data               = '0;
    endcase
  end
`else
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_plain
    assign out_port[gi] = data_reg[gi];
  end

  always_comb begin
    rd_data = '0;
    if (bus.address == ADDR_DATA) begin
      rd_data[WIDTH-1:0] = data_reg;
    end
  end
`endif

  assign bus.readdata = rd_data;

endmodule

// File: tb/tb_my_processor_pio_out.sv
// Self-checking bench for my_processor_pio_out: directed scenarios plus random
// bus traffic checked every cycle against a time-based behavioural model.
module tb_my_processor_pio_out;

`ifdef MY_PROCESSOR_PIO_OUT_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] out_port;
  logic       chk_en;
  int         checks;
  int         errors;

  my_processor_pio_out_if bus_if ();

  my_processor_pio_out #(
    .WIDTH       (4),
    .RESET_VALUE (4'hA),
    .PERIOD_W    (24)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase derived from elapsed clocks since the last period load.
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  logic [23:0] m_period;
  longint      m_t;

  function automatic logic m_phase();
    if (m_period == 24'd0) return 1'b0;
    return ((m_t / longint'(m_period)) % 2) != 0;
  endfunction

  function automatic logic [3:0] m_out();
    return m_data ^ (m_mask & {4{m_phase()}});
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {28'd0, m_data};
      3'd4:    return {28'd0, m_mask};
      3'd5:    return {8'd0, m_period};
      3'd6:    return {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_data   = 4'hA;
      m_mask   = 4'h0;
      m_period = 24'd0;
      m_t      = 0;
    end else begin
      m_t = m_t + 1;
      if (bus_if.chipselect && !bus_if.write_n) begin
        case (bus_if.address)
          3'd0: m_data = bus_if.writedata[3:0];
          3'd1: m_data = m_data | bus_if.writedata[3:0];
          3'd2: m_data = m_data & ~bus_if.writedata[3:0];
          3'd3: m_data = m_data ^ bus_if.writedata[3:0];
          3'd4: if (BLINK) m_mask = bus_if.writedata[3:0];
          3'd5: if (BLINK) begin
            m_period = bus_if.writedata[23:0];
            m_t      = 0;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_out_port", {28'd0, out_port}, {28'd0, m_out()});
      check("cycle_readdata", bus_if.readdata, m_rd(bus_if.address));
    end
  end

  task automatic cyc(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus_if.address    = a;
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.writedata  = wd;
    @(posedge clk);
    #1;
    $display("cycle rst=%0b addr=%0d cs=%0b wn=%0b wd=%h -> out_port=%h", reset, a, cs, wn, wd, out_port);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cyc(a, 1'b1, 1'b0, wd);
  endtask

  task automatic idle();
    cyc(3'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic peek(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus_if.address    = a;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    #1;
    check(name, bus_if.readdata, exp);
  endtask

  initial begin
    logic [11:0] pat;
    logic [2:0]  ra;
    logic        rcs;
    logic        rwn;
    logic [31:0] rwd;

    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    check("reset_out_port", {28'd0, out_port}, 32'h0000000A);
    peek(3'd0, 32'h0000000A, "reset_rd_data");
    peek(3'd6, 32'h00000000, "reset_rd_status");

    wr(3'd0, 32'h3); check("data_write", {28'd0, out_port}, 32'h3);
    wr(3'd1, 32'h8); check("set_write", {28'd0, out_port}, 32'hB);
    wr(3'd2, 32'h1); check("clear_write", {28'd0, out_port}, 32'hA);
    wr(3'd3, 32'hF); check("toggle_write", {28'd0, out_port}, 32'h5);

    wr(3'd0, 32'hFFFFFFF0);
    peek(3'd0, 32'h0, "upper_bits_ignored");
    wr(3'd6, 32'hFFFFFFFF);
    check("status_write_out", {28'd0, out_port}, 32'h0);
    peek(3'd0, 32'h0, "status_write_data");
    peek(3'd6, 32'h0, "status_write_phase");

    if (BLINK) begin
      wr(3'd4, 32'h1);
      wr(3'd5, 32'h3);
      pat = 12'b111000111000;
      for (int i = 0; i < 12; i++) begin
        check("blink_bit0", {31'd0, out_port[0]}, {31'd0, pat[i]});
        check("blink_upper", {29'd0, out_port[3:1]}, 32'd0);
        idle();
      end
      repeat (3) idle();
      check("blink_phase_high", {28'd0, out_port}, 32'h1);
      wr(3'd5, 32'h5);
      check("reload_phase_low", {28'd0, out_port}, 32'h0);
      repeat (4) idle();
      check("reload_still_low", {28'd0, out_port}, 32'h0);
      idle();
      check("reload_toggle", {28'd0, out_port}, 32'h1);
      wr(3'd5, 32'h0);
      repeat (6) idle();
      check("period0_out", {28'd0, out_port}, 32'h0);
      peek(3'd6, 32'h0, "period0_phase");
      peek(3'd5, 32'h0, "period0_rd");

      wr(3'd0, 32'h5);
      wr(3'd4, 32'hF);
      wr(3'd5, 32'h2);
      repeat (3) idle();
      reset = 1'b1;
      wr(3'd1, 32'hF);
      reset = 1'b0;
      check("reset_vs_set_out", {28'd0, out_port}, 32'hA);
      peek(3'd0, 32'hA, "reset_vs_set_data");
      peek(3'd4, 32'h0, "reset_vs_set_mask");
      peek(3'd5, 32'h0, "reset_vs_set_period");
    end else begin
      wr(3'd4, 32'hF);
      wr(3'd5, 32'h7);
      peek(3'd4, 32'h0, "noblink_mask_rd");
      peek(3'd5, 32'h0, "noblink_period_rd");
      wr(3'd0, 32'h6);
      check("noblink_out", {28'd0, out_port}, 32'h6);
      peek(3'd6, 32'h0, "noblink_status_rd");
    end

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      ra    = 3'($urandom_range(0, 7));
      rcs   = ($urandom_range(0, 3) != 0);
      rwn   = ($urandom_range(0, 2) == 0);
      rwd   = (ra == 3'd5 && $urandom_range(0, 7) != 0) ? $urandom_range(0, 6) : $urandom;
      cyc(ra, rcs, rwn, rwd);
    end
    reset = 1'b0;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
